// File: rtl/esdi_cmd_scheduler_if.sv
// Requester, completion and serial-engine handshake bundle for esdi_cmd_scheduler.
// slave = scheduler side, master = requesters/engine side.
interface esdi_cmd_scheduler_if;
  logic        req0_valid;
  logic        req1_valid;
  logic        req0_ready;
  logic        req1_ready;
  logic [16:0] req0_word;
  logic [16:0] req1_word;
  logic        rsp0_valid;
  logic        rsp1_valid;
  logic        rsp0_ready;
  logic        rsp1_ready;
  logic [17:0] rsp0_word;
  logic [17:0] rsp1_word;
  logic        eng_cmd_valid;
  logic        eng_cmd_ready;
  logic [16:0] eng_cmd_word;
  logic        eng_rsp_valid;
  logic [17:0] eng_rsp_word;

  modport slave (
    input  req0_valid, req1_valid, req0_word, req1_word,
    input  rsp0_ready, rsp1_ready, eng_cmd_ready, eng_rsp_valid, eng_rsp_word,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_word, rsp1_word,
    output eng_cmd_valid, eng_cmd_word
  );

  modport master (
    output req0_valid, req1_valid, req0_word, req1_word,
    output rsp0_ready, rsp1_ready, eng_cmd_ready, eng_rsp_valid, eng_rsp_word,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_word, rsp1_word,
    input  eng_cmd_valid, eng_cmd_word
  );
endinterface

// File: rtl/esdi_cmd_scheduler.sv
// Round-robin sharing of the ESDI serial command engine between the CSR path (0) and the
// status poller (1); one transaction in flight, held until response, Command Complete or timeout.
//   state       | meaning
//   S_IDLE      | offer ready to the arbitration winner
//   S_ISSUE     | present latched word to the engine
//   S_WAIT_RESP | query: wait for engine result or timeout
//   S_WAIT_CC   | command: wait CC high (drive busy) then low, or timeout
//   S_RETURN    | hold completion until the requester takes it
module esdi_cmd_scheduler #(
  parameter int unsigned CC_TIMEOUT  = 50_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  csr_aclk,
  input  logic                  csr_aresetn,
  esdi_cmd_scheduler_if.slave   bus,
  input  logic                  esdi_command_complete,
  input  logic                  esdi_attention,
  output logic                  attention_flag,
  input  logic                  attention_clr,
  output logic                  busy,
  output logic                  grant_id
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_RESP, S_WAIT_CC, S_RETURN} state_t;

  state_t                 state_q, state_d;
  logic [16:0]            word_q, word_d;
  logic                   grant_q, grant_d;
  logic                   rr_q, rr_d;
  logic                   phase_q, phase_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [17:0]            rsp0_word_q, rsp0_word_d;
  logic [17:0]            rsp1_word_q, rsp1_word_d;
  logic                   attn_flag_q, attn_flag_d;
  logic [SYNC_STAGES-1:0] cc_sync_q, cc_sync_d;
  logic [SYNC_STAGES-1:0] attn_sync_q, attn_sync_d;

  logic        cc_s, attn_s, pick, tmo, rsp_load;
  logic [17:0] rsp_val;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, eng_cmd_valid;

  always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
    if (!csr_aresetn) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      grant_q     <= 1'b0;
      rr_q        <= 1'b0;
      phase_q     <= 1'b0;
      cnt_q       <= '0;
      rsp0_word_q <= '0;
      rsp1_word_q <= '0;
      attn_flag_q <= 1'b0;
      cc_sync_q   <= '1;
      attn_sync_q <= '1;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      rsp0_word_q <= rsp0_word_d;
      rsp1_word_q <= rsp1_word_d;
      attn_flag_q <= attn_flag_d;
      cc_sync_q   <= cc_sync_d;
      attn_sync_q <= attn_sync_d;
    end
  end

  always_comb begin
    cc_sync_d   = {cc_sync_q[SYNC_STAGES-2:0], esdi_command_complete};
    attn_sync_d = {attn_sync_q[SYNC_STAGES-2:0], esdi_attention};
    cc_s        = cc_sync_q[SYNC_STAGES-1];
    attn_s      = attn_sync_q[SYNC_STAGES-1];
    // On a tie the pointer names the requester not served last; otherwise whoever is asking.
    pick = (bus.req0_valid & bus.req1_valid) ? rr_q : bus.req1_valid;
    tmo  = (cnt_q == 32'(CC_TIMEOUT));

    state_d       = state_q;
    word_d        = word_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    phase_d       = phase_q;
    rsp0_word_d   = rsp0_word_q;
    rsp1_word_d   = rsp1_word_q;
    rsp_load      = 1'b0;
    rsp_val       = 18'h0;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    rsp0_valid    = 1'b0;
    rsp1_valid    = 1'b0;
    eng_cmd_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        req0_ready = bus.req0_valid & ~pick;
        req1_ready = bus.req1_valid & pick;
        if (bus.req0_valid | bus.req1_valid) begin
          word_d  = pick ? bus.req1_word : bus.req0_word;
          grant_d = pick;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        eng_cmd_valid = 1'b1;
        phase_d       = 1'b0;
        if (bus.eng_cmd_ready) state_d = word_q[16] ? S_WAIT_RESP : S_WAIT_CC;
      end
      S_WAIT_RESP: begin
        if (bus.eng_rsp_valid) begin
          rsp_load = 1'b1;
          rsp_val  = bus.eng_rsp_word;
          state_d  = S_RETURN;
        end else if (tmo) begin
          rsp_load = 1'b1;
          rsp_val  = 18'h2_0000;
          state_d  = S_RETURN;
        end
      end
      S_WAIT_CC: begin
        if (phase_q && !cc_s) begin
          rsp_load = 1'b1;
          state_d  = S_RETURN;
        end else if (tmo) begin
          rsp_load = 1'b1;
          rsp_val  = 18'h2_0000;
          state_d  = S_RETURN;
        end else if (!phase_q && cc_s) begin
          phase_d = 1'b1;
        end
      end
      S_RETURN: begin
        rsp0_valid = ~grant_q;
        rsp1_valid = grant_q;
        if (grant_q ? bus.rsp1_ready : bus.rsp0_ready) begin
          state_d = S_IDLE;
          rr_d    = ~grant_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rsp_load) begin
      if (grant_q) rsp1_word_d = rsp_val;
      else         rsp0_word_d = rsp_val;
    end

    // Cleared on every state entry, otherwise counts up and saturates.
    if (state_d != state_q)        cnt_d = '0;
    else if (cnt_q == 32'hFFFF_FFFF) cnt_d = cnt_q;
    else                           cnt_d = cnt_q + 32'd1;

    attn_flag_d = ~attn_s | (attn_flag_q & ~attention_clr);
  end

  assign bus.req0_ready    = req0_ready;
  assign bus.req1_ready    = req1_ready;
  assign bus.rsp0_valid    = rsp0_valid;
  assign bus.rsp1_valid    = rsp1_valid;
  assign bus.rsp0_word     = rsp0_word_q;
  assign bus.rsp1_word     = rsp1_word_q;
  assign bus.eng_cmd_valid = eng_cmd_valid;
  assign bus.eng_cmd_word  = word_q;
  assign attention_flag    = attn_flag_q;
  assign busy              = (state_q != S_IDLE);
  assign grant_id          = grant_q;

endmodule
